vga_sprite_module: RTL and testbench

- Parametrised successor to the fixed 64x64 monochrome picture controller.
- Sits between sync_module and a 1-bit-per-pixel image ROM.
- Places an IMG_W x IMG_H image anywhere on screen, with integer scaling and fixed foreground/background colours.
- Optionally bounces the image around the active area, one step per frame.
- Delays HSYNC/VSYNC internally so sync stays aligned with the colour pipeline.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_sprite_module_if.sv | 14 +
 rtl/sprite_pos_module.sv | 67 ++++++
 rtl/vga_sprite_module.sv | 110 +++++++++++
 tb/tb_vga_sprite_module.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area timing, colour constants and the
// position/direction types used by the sprite placement logic.
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef logic [2:0] rgb_t;  // {R,G,B}
  localparam rgb_t COLOR_BLACK = 3'b000;
  localparam rgb_t COLOR_WHITE = 3'b111;

  typedef enum logic { DIR_POS = 1'b0, DIR_NEG = 1'b1 } dir_e;

  // One axis of sprite placement: 12-bit unsigned so pos+STEP never wraps.
  typedef struct packed {
    logic [11:0] pos;
    dir_e        dir;
  } axis_t;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // One bounce step against [0, lim]; direction flips when an edge is hit.
  function automatic axis_t bounce_step(input axis_t cur, input logic [11:0] lim,
                                        input logic [11:0] step);
    axis_t nxt;
    nxt = cur;
    if (cur.dir == DIR_POS) begin
      if (cur.pos + step >= lim) begin
        nxt.pos = lim;
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = cur.pos + step;
      end
    end else if (cur.pos <= step) begin
      nxt.pos = '0;
      nxt.dir = DIR_POS;
    end else begin
      nxt.pos = cur.pos - step;
    end
    return nxt;
  endfunction

  function automatic logic [11:0] clamp12(input logic [10:0] v, input logic [11:0] lim);
    return ({1'b0, v} > lim) ? lim : {1'b0, v};
  endfunction
endpackage

// File: rtl/vga_sprite_module_if.sv
// Image ROM port: the sprite controller (master) issues a row address and
// receives the 1bpp row word (MSB = leftmost pixel) ROM_LAT cycles later.
//   Rom_Addr : row address, master -> ROM
//   Rom_Data : row word,    ROM -> master
interface vga_sprite_module_if #(
  parameter int ADDR_W = 6,
  parameter int IMG_W  = 64
);
  logic [ADDR_W-1:0] Rom_Addr;
  logic [IMG_W-1:0]  Rom_Data;

  modport master (output Rom_Addr, input Rom_Data);
  modport slave  (input Rom_Addr, output Rom_Data);
endinterface

// File: rtl/sprite_pos_module.sv
// Sprite placement: detects the frame tick (falling edge of registered
// VSYNC_In) and on each tick either clamps to the static start position or
// steps the bounce state per axis.
//   CLK, RSTn        : clock, async active-low reset
//   VSYNC_In         : raw VSYNC, active low
//   Mode_Sig         : 0 static, 1 bounce (sampled on the tick cycle)
//   Start_X/Start_Y  : static-mode top-left corner
//   Pos_X/Pos_Y      : current top-left corner of the sprite
module sprite_pos_module #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int SW       = 64,
  parameter int SH       = 64,
  parameter int STEP     = 2
)(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        VSYNC_In,
  input  logic        Mode_Sig,
  input  logic [10:0] Start_X,
  input  logic [10:0] Start_Y,
  output logic [11:0] Pos_X,
  output logic [11:0] Pos_Y
);
  import vga_pkg::*;

  localparam logic [11:0] LIM_X  = 12'(H_ACTIVE - SW);
  localparam logic [11:0] LIM_Y  = 12'(V_ACTIVE - SH);
  localparam logic [11:0] STEP_W = 12'(STEP);

  logic  vs_q, vs_qq, tick;
  axis_t x_q, x_d, y_q, y_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      x_q   <= '{pos: 12'd0, dir: DIR_POS};
      y_q   <= '{pos: 12'd0, dir: DIR_POS};
    end else begin
      vs_q  <= VSYNC_In;
      vs_qq <= vs_q;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign tick = vs_qq & ~vs_q;

  // Position only moves on the tick so a frame is never drawn split.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (Mode_Sig) begin
        x_d = bounce_step(x_q, LIM_X, STEP_W);
        y_d = bounce_step(y_q, LIM_Y, STEP_W);
      end else begin
        x_d.pos = clamp12(Start_X, LIM_X);
        y_d.pos = clamp12(Start_Y, LIM_Y);
      end
    end
  end

  assign Pos_X = x_q.pos;
  assign Pos_Y = y_q.pos;
endmodule

// File: rtl/vga_sprite_module.sv
// Sprite controller: draws an IMG_W x IMG_H 1bpp image, scaled by
// 2^SCALE_LOG2, at a static or bouncing position. Colour and delayed
// sync appear LAT = 2+ROM_LAT cycles after the inputs are sampled.
//   CLK, RSTn                  : pixel clock, async active-low reset
//   Ready_Sig, Column/Row_Addr : active-area flag and pixel coordinates
//   HSYNC_In, VSYNC_In         : raw sync from the timing generator
//   Mode_Sig, Start_X, Start_Y : placement control
//   rom                        : image ROM port (Rom_Addr / Rom_Data)
//   HSYNC_Sig, VSYNC_Sig       : sync delayed to match colour
//   Red/Green/Blue_Sig         : pixel colour
module vga_sprite_module #(
  parameter int         H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int         V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int         IMG_W      = 64,
  parameter int         IMG_H      = 64,
  parameter int         ADDR_W     = 6,
  parameter int         SCALE_LOG2 = 0,
  parameter int         ROM_LAT    = 1,
  parameter int         STEP       = 2,
  parameter logic [2:0] FG_COLOR   = vga_pkg::COLOR_WHITE,
  parameter logic [2:0] BG_COLOR   = vga_pkg::COLOR_BLACK
)(
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                Ready_Sig,
  input  logic [10:0]         Column_Addr_Sig,
  input  logic [10:0]         Row_Addr_Sig,
  input  logic                HSYNC_In,
  input  logic                VSYNC_In,
  input  logic                Mode_Sig,
  input  logic [10:0]         Start_X,
  input  logic [10:0]         Start_Y,
  vga_sprite_module_if.master rom,
  output logic                HSYNC_Sig,
  output logic                VSYNC_Sig,
  output logic                Red_Sig,
  output logic                Green_Sig,
  output logic                Blue_Sig
);
  import vga_pkg::*;

  localparam int          LAT    = 2 + ROM_LAT;
  localparam int          LCOL_W = $clog2(IMG_W);
  localparam logic [11:0] SW     = 12'(IMG_W << SCALE_LOG2);
  localparam logic [11:0] SH     = 12'(IMG_H << SCALE_LOG2);

  logic [11:0] pos_x, pos_y;

  sprite_pos_module #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .SW(IMG_W << SCALE_LOG2), .SH(IMG_H << SCALE_LOG2), .STEP(STEP)
  ) u_pos (
    .CLK(CLK), .RSTn(RSTn), .VSYNC_In(VSYNC_In), .Mode_Sig(Mode_Sig),
    .Start_X(Start_X), .Start_Y(Start_Y), .Pos_X(pos_x), .Pos_Y(pos_y)
  );

  // Stage 0 input capture; stage 1 window test and ROM address;
  // stages 2..LAT-1 wait for ROM data; stage LAT colour.
  logic [10:0]                   col_q, row_q;
  logic                          rdy_q;
  sync_t [LAT:0]                 sync_pipe_q;
  logic [LAT-1:1]                vld_pipe_q;   // In_Win per stage
  logic [LAT-1:1][LCOL_W-1:0]    lcol_pipe_q;
  logic [ADDR_W-1:0]             rom_addr_q;
  rgb_t                          rgb_q;

  logic [11:0]       dx, dy;
  logic              in_win;
  logic [LCOL_W-1:0] pix_idx;
  logic              pix_bit;

  // A coordinate left of/above the sprite would wrap dx/dy to a large
  // value, so the explicit >= checks keep the window test honest.
  assign dx     = {1'b0, col_q} - pos_x;
  assign dy     = {1'b0, row_q} - pos_y;
  assign in_win = rdy_q && ({1'b0, col_q} >= pos_x) && (dx < SW) &&
                  ({1'b0, row_q} >= pos_y) && (dy < SH);

  assign pix_idx = LCOL_W'(IMG_W - 1) - lcol_pipe_q[LAT-1];
  assign pix_bit = rom.Rom_Data[pix_idx];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col_q       <= '0;
      row_q       <= '0;
      rdy_q       <= 1'b0;
      sync_pipe_q <= '1;  // idle sync is high on both lines
      vld_pipe_q  <= '0;
      lcol_pipe_q <= '0;
      rom_addr_q  <= '0;
      rgb_q       <= COLOR_BLACK;
    end else begin
      col_q       <= Column_Addr_Sig;
      row_q       <= Row_Addr_Sig;
      rdy_q       <= Ready_Sig;
      sync_pipe_q <= {sync_pipe_q[LAT-1:0], HSYNC_In, VSYNC_In};
      vld_pipe_q  <= {vld_pipe_q[LAT-2:1], in_win};
      lcol_pipe_q <= {lcol_pipe_q[LAT-2:1], LCOL_W'(dx >> SCALE_LOG2)};
      // Holding the address outside the window avoids needless ROM toggling.
      if (in_win) rom_addr_q <= ADDR_W'(dy >> SCALE_LOG2);
      if (vld_pipe_q[LAT-1]) rgb_q <= pix_bit ? FG_COLOR : BG_COLOR;
      else                   rgb_q <= COLOR_BLACK;
    end
  end

  assign rom.Rom_Addr = rom_addr_q;
  assign HSYNC_Sig    = sync_pipe_q[LAT].hs;
  assign VSYNC_Sig    = sync_pipe_q[LAT].vs;
  assign {Red_Sig, Green_Sig, Blue_Sig} = rgb_q;
endmodule

// File: tb/tb_vga_sprite_module.sv
// Bench: two instances share stimulus -- d0 with default parameters, d1
// with 2x scaling and distinct FG/BG colours. Expected colours are hand
// computed from the ROM image word(r) = A5A5..A5 ^ r (row r).
module tb_vga_sprite_module;
  logic        CLK = 1'b0, RSTn = 1'b0;
  logic        ready, hs_in, vs_in, mode;
  logic [10:0] col, row, sx, sy;
  logic        hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  typedef struct {
    int         due;
    string      nm;
    logic [4:0] e0;
    logic [4:0] e1;
  } exp_t;
  exp_t sbq[$];

  vga_sprite_module_if #(.ADDR_W(6), .IMG_W(64)) rif0 ();
  vga_sprite_module_if #(.ADDR_W(6), .IMG_W(64)) rif1 ();

  vga_sprite_module dut0 (
    .CLK(CLK), .RSTn(RSTn), .Ready_Sig(ready), .Column_Addr_Sig(col),
    .Row_Addr_Sig(row), .HSYNC_In(hs_in), .VSYNC_In(vs_in), .Mode_Sig(mode),
    .Start_X(sx), .Start_Y(sy), .rom(rif0), .HSYNC_Sig(hs0), .VSYNC_Sig(vs0),
    .Red_Sig(r0), .Green_Sig(g0), .Blue_Sig(b0));

  vga_sprite_module #(.SCALE_LOG2(1), .FG_COLOR(3'b101), .BG_COLOR(3'b010)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .Ready_Sig(ready), .Column_Addr_Sig(col),
    .Row_Addr_Sig(row), .HSYNC_In(hs_in), .VSYNC_In(vs_in), .Mode_Sig(mode),
    .Start_X(sx), .Start_Y(sy), .rom(rif1), .HSYNC_Sig(hs1), .VSYNC_Sig(vs1),
    .Red_Sig(r1), .Green_Sig(g1), .Blue_Sig(b1));

  function automatic logic [63:0] rom_word(input logic [5:0] a);
    return 64'hA5A5_A5A5_A5A5_A5A5 ^ {58'd0, a};
  endfunction

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) rif0.Rom_Data <= rom_word(rif0.Rom_Addr);
  always @(posedge CLK) rif1.Rom_Data <= rom_word(rif1.Rom_Addr);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: pops each expectation on the cycle its output is due.
  always @(negedge CLK) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due != cyc) chk({e.nm, "/late"}, 8'(cyc), 8'(e.due));
      chk({e.nm, "/d0"}, {3'b0, hs0, vs0, r0, g0, b0}, {3'b0, e.e0});
      chk({e.nm, "/d1"}, {3'b0, hs1, vs1, r1, g1, b1}, {3'b0, e.e1});
    end
  end

  task automatic drive_idle();
    ready = 1'b0; hs_in = 1'b1; vs_in = 1'b1; col = '0; row = '0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called 1 time unit after a rising edge; output due 4 edges later
  // (sampled on the next edge, then LAT=3).
  task automatic pix(input string nm, input int c, input int r, input bit rdy,
                     input bit hs, input bit vs, input logic [2:0] x0, input logic [2:0] x1);
    exp_t e;
    col = 11'(c); row = 11'(r); ready = rdy; hs_in = hs; vs_in = vs;
    e.due = cyc + 4; e.nm = nm; e.e0 = {hs, vs, x0}; e.e1 = {hs, vs, x1};
    sbq.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic pxl(input string nm, input int c, input int r,
                     input logic [2:0] x0, input logic [2:0] x1);
    pix(nm, c, r, 1'b1, 1'b1, 1'b1, x0, x1);
  endtask

  task automatic frame_tick();
    pix("vs_lo_a", 0, 0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    pix("vs_lo_b", 0, 0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    idle(4);
  endtask

  initial begin
    drive_idle(); mode = 1'b0; sx = '0; sy = '0;
    repeat (3) @(posedge CLK); #1;
    chk("rst_out0", {3'b0, hs0, vs0, r0, g0, b0}, 8'h18);
    chk("rst_out1", {3'b0, hs1, vs1, r1, g1, b1}, 8'h18);
    chk("rst_addr0", 8'(rif0.Rom_Addr), 8'h00);
    chk("rst_addr1", 8'(rif1.Rom_Addr), 8'h00);
    @(negedge CLK) RSTn = 1'b1;
    @(posedge CLK); #1;

    // Static at (100,50): d0 window 100..163 x 50..113, d1 100..227 x 50..177
    sx = 11'd100; sy = 11'd50; frame_tick();
    pxl("p100_50", 100, 50, 3'b111, 3'b101);
    pxl("p99_50",   99, 50, 3'b000, 3'b000);
    pxl("p164_50", 164, 50, 3'b000, 3'b101);
    pxl("p163_50", 163, 50, 3'b111, 3'b101);
    pxl("p101_50", 101, 50, 3'b000, 3'b101);
    pxl("p102_50", 102, 50, 3'b111, 3'b010);
    pix("rdy0", 100, 50, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);
    pxl("p100_113", 100, 113, 3'b111, 3'b101);
    pxl("p100_114", 100, 114, 3'b000, 3'b101);
    pxl("p163_51", 163, 51, 3'b000, 3'b101);
    pxl("p227_50", 227, 50, 3'b000, 3'b101);
    pxl("p228_50", 228, 50, 3'b000, 3'b000);
    idle(6);

    // Origin: scaling checks on d1, then sync alignment with colour
    sx = 11'd0; sy = 11'd0; frame_tick();
    pxl("s0_0",     0, 0, 3'b111, 3'b101);
    pxl("s1_0",     1, 0, 3'b000, 3'b101);
    pxl("s2_0",     2, 0, 3'b111, 3'b010);
    pxl("s127_0", 127, 0, 3'b000, 3'b101);
    pxl("s128_0", 128, 0, 3'b000, 3'b000);
    pxl("s127_1", 127, 1, 3'b000, 3'b101);
    pxl("s127_2", 127, 2, 3'b000, 3'b010);
    pxl("s127_3", 127, 3, 3'b000, 3'b010);
    pxl("s127_4", 127, 4, 3'b000, 3'b101);
    pxl("s63_1",   63, 1, 3'b000, 3'b101);
    pix("sync_a", 0, 0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b101);
    pix("sync_b", 1, 0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b101);
    pix("sync_c", 2, 0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b010);
    pix("sync_d", 0, 0, 1'b1, 1'b1, 1'b1, 3'b111, 3'b101);
    idle(6);

    // Clamp: d0 -> (736,536), d1 -> (672,472)
    sx = 11'd790; sy = 11'd590; frame_tick();
    pxl("c736_536", 736, 536, 3'b111, 3'b101);
    pxl("c735_536", 735, 536, 3'b000, 3'b101);
    pxl("c736_535", 736, 535, 3'b000, 3'b101);
    pxl("c799_599", 799, 599, 3'b000, 3'b010);
    pxl("c799_598", 799, 598, 3'b111, 3'b010);
    idle(6);

    // Bounce from d0 (732,0), d1 (672,0)
    sx = 11'd732; sy = 11'd0; frame_tick();
    mode = 1'b1;
    frame_tick();  // d0 (734,2)  d1 (672,2) dir_x flips
    pxl("b1_734_2", 734, 2, 3'b111, 3'b101);
    pxl("b1_733_2", 733, 2, 3'b000, 3'b010);
    pxl("b1_734_1", 734, 1, 3'b000, 3'b000);
    pxl("b1_672_2", 672, 2, 3'b000, 3'b101);
    pxl("b1_671_2", 671, 2, 3'b000, 3'b000);
    idle(2);
    frame_tick();  // d0 (736,4) dir_x flips, d1 (670,4)
    pxl("b2_736_4", 736, 4, 3'b111, 3'b010);
    pxl("b2_735_4", 735, 4, 3'b000, 3'b101);
    pxl("b2_670_4", 670, 4, 3'b000, 3'b101);
    pxl("b2_669_4", 669, 4, 3'b000, 3'b000);
    pxl("b2_736_3", 736, 3, 3'b000, 3'b000);
    idle(2);
    frame_tick();  // d0 (734,6), d1 (668,6)
    pxl("b3_734_6", 734, 6, 3'b111, 3'b010);
    pxl("b3_733_6", 733, 6, 3'b000, 3'b101);
    pxl("b3_668_6", 668, 6, 3'b000, 3'b101);
    pxl("b3_667_6", 667, 6, 3'b000, 3'b000);
    pxl("b3_734_5", 734, 5, 3'b000, 3'b000);
    idle(6);

    // Reset with a white pixel on the output
    mode = 1'b0; sx = 11'd100; sy = 11'd50; frame_tick();
    col = 11'd100; row = 11'd50; ready = 1'b1; hs_in = 1'b0; vs_in = 1'b1;
    @(posedge CLK); #1;
    drive_idle();
    repeat (3) @(posedge CLK); #1;
    chk("pre_rst_d0", {3'b0, hs0, vs0, r0, g0, b0}, 8'h0F);
    chk("pre_rst_d1", {3'b0, hs1, vs1, r1, g1, b1}, 8'h0D);
    RSTn = 1'b0; #1;
    chk("mid_rst_d0", {3'b0, hs0, vs0, r0, g0, b0}, 8'h18);
    chk("mid_rst_d1", {3'b0, hs1, vs1, r1, g1, b1}, 8'h18);
    @(negedge CLK); @(negedge CLK) RSTn = 1'b1;
    @(posedge CLK); #1;
    pxl("post_rst_0_0",     0,  0, 3'b111, 3'b101);
    pxl("post_rst_100_50", 100, 50, 3'b000, 3'b101);
    idle(2);
    frame_tick();
    pxl("tick_100_50", 100, 50, 3'b111, 3'b101);
    pxl("tick_0_0",      0,  0, 3'b000, 3'b000);
    idle(2);

    repeat (20) begin
      if (sbq.size() == 0) break;
      @(posedge CLK);
    end
    if (sbq.size() != 0) chk("drain", 8'(sbq.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
